// File: rtl/llc_hazard_pipe.sv
// Elastic LLC request pipeline with per-set ordering: a request cannot enter while
// another request to the same set is still in flight. Bubbles collapse, and flush drops all entries.
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 11
`endif

module llc_hazard_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = `LLC_SET_BITS,
    parameter int NUM_STAGES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SET_BITS-1:0]               in_set,
    input  logic                              in_nohaz,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SET_BITS-1:0]               out_set,
    output logic [DATA_WIDTH-1:0]             out_data,
    input  logic                              flush,
    output logic                              busy,
    output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy,
    output logic [CNT_WIDTH-1:0]              hazard_stall_cnt
);

    localparam int OCC_W = $clog2(NUM_STAGES+1);

    logic [NUM_STAGES-1:0] vld;
    logic [SET_BITS-1:0]   set_q  [NUM_STAGES];
    logic [DATA_WIDTH-1:0] data_q [NUM_STAGES];
    logic [NUM_STAGES-1:0] adv;
    logic                  retire;
    logic                  haz;
    logic                  stall_inc;

    // adv[i] means register i loads this edge: from stage i-1, or from the input for stage 0
    always_comb begin
        adv = '0;
        adv[NUM_STAGES-1] = out_ready | ~vld[NUM_STAGES-1];
        for (int i = NUM_STAGES-2; i >= 0; i--) begin
            adv[i] = adv[i+1] | ~vld[i];
        end
    end

    assign retire = vld[NUM_STAGES-1] & out_ready;

    // The retiring entry no longer blocks its set, so a same-set follower enters in that cycle
    always_comb begin
        haz = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (vld[i] && (set_q[i] == in_set) && !((i == NUM_STAGES-1) && retire)) begin
                haz = 1'b1;
            end
        end
        if (in_nohaz) begin
            haz = 1'b0;
        end
    end

    assign in_ready  = rst & ~flush & adv[0] & ~haz;
    assign stall_inc = in_valid & adv[0] & haz & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld              <= '0;
            hazard_stall_cnt <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                set_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (stall_inc && (hazard_stall_cnt != '1)) begin
                hazard_stall_cnt <= hazard_stall_cnt + 1'b1;
            end
            if (flush) begin
                vld <= '0;
            end else begin
                for (int i = NUM_STAGES-1; i >= 1; i--) begin
                    if (adv[i]) begin
                        vld[i]    <= vld[i-1];
                        set_q[i]  <= set_q[i-1];
                        data_q[i] <= data_q[i-1];
                    end
                end
                if (adv[0]) begin
                    vld[0]    <= in_valid & in_ready;
                    set_q[0]  <= in_set;
                    data_q[0] <= in_data;
                end
            end
        end
    end

    assign out_valid = vld[NUM_STAGES-1];
    assign out_set   = set_q[NUM_STAGES-1];
    assign out_data  = data_q[NUM_STAGES-1];
    assign busy      = |vld;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            occupancy = occupancy + OCC_W'(vld[i]);
        end
    end

endmodule
